seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed display driver: watches the scanned `seven`/`tube` bus and reconstructs the 8-digit hex value being shown.
- Used as an on-board self-test monitor and as the checker in display-path benches.
- Samples the bus on an internal strobe and filters scan glitches.
- Stores one 4-bit code per digit position and reports complete scan frames and illegal patterns.

Parameters:
- SAMPLE_DIV, 50: clk1M cycles per sample strobe (2..1023); strobe fires when the divider counter reaches SAMPLE_DIV-1.
- STABLE_CNT, 4: consecutive identical samples required before a digit is committed (1..15).
- TIMEOUT, 400: samples without refresh before a digit is marked stale (optional feature only).

Ports:
- clk1M  input  1  1 MHz system clock
- rst  input  1  reset, asynchronous, active-high
- seven  input  7  segment pattern {a,b,c,d,e,f,g}, active-high
- tube  input  8  digit select, active-low; tube[i]=0 selects digit i
- digits  output  32  committed hex codes; digits[4i+3:4i] = digit i
- blank  output  8  blank[i]=1: digit i last committed as all-segments-off
- frame_done  output  1  one-cycle pulse when all 8 digits committed since last pulse
- seg_err  output  1  sticky: a stable, non-blank pattern matched no hex glyph
- tube_err  output  1  sticky: a stable tube value had zero or >1 low bits (tube=8'hFF counts as idle, not an error)

Behaviour:
- Reset (async, immediate on rst=1): digits=0, blank=8'hFF, frame_done=0, seg_err=0, tube_err=0; divider, stability counter, seen-mask and previous-sample registers cleared.
- Strobe: one clk1M cycle every SAMPLE_DIV cycles; all other logic advances only on strobe cycles.
- Sample register holds the {tube,seven} value taken at the previous strobe.
- On each strobe:
  - If {tube,seven} equals the previous sample, increment the stability counter, saturating at 15.
  - Otherwise, reset the stability counter to 1 and store the new sample.
- Commit: fires exactly once per stable run, on the strobe where the counter becomes STABLE_CNT. No re-commit while the run continues.
- Commit actions, by tube value:
  - tube=8'hFF: ignore.
  - tube not one-hot-low: set tube_err; no digit update.
  - tube one-hot-low at index i, seven=0: blank[i]=1; digits nibble i unchanged.
  - tube one-hot-low at index i, seven matches a glyph: digits nibble i = code, blank[i]=0.
  - tube one-hot-low at index i, any other seven pattern: set seg_err; nibble i and blank[i] unchanged.
  - Any one-hot commit (valid, blank or invalid) sets seen[i].
- Glyph table (hex of seven):
  - 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70
  - 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47
- Frame:
  - When seen becomes 8'hFF, pulse frame_done for exactly 1 clk1M cycle, in the cycle after the commit that completes the mask.
  - Clear seen in that same cycle.
  - A commit of digit i in the same cycle as the clear sets seen[i] in the new frame; it is not lost.
- Latency: a scan value held stable from strobe k commits at strobe k+STABLE_CNT-1. Outputs register one cycle later.
- Boundary cases:
  - Recommitting the same digit within a frame does not advance the frame.
  - seg_err and tube_err clear only on rst.
  - rst asserted mid-run discards the partial run and the frame mask.

Optional Feature:
- Macro: SEG_STALE_TIMEOUT_EN.
- Defined:
  - Each digit has a 9-bit age counter, cleared on any commit to that digit and incremented on each strobe (saturating).
  - When an age counter reaches TIMEOUT, force blank[i]=1.
  - Also adds output port `stale` (8 bits); stale[i]=1 while the age is at or above TIMEOUT; resets to 0.
- Undefined: no age counters and no `stale` port; blank changes only on commits.

Test Plan:
- Reset: rst=1 mid-operation -> digits=0, blank=FF, frame_done=0, errors=0 within the same cycle.
- Full frame: scan digits 0..7 with glyphs 1,2,3,4,5,6,7,8, each held 5 strobes, STABLE_CNT=4 -> digits=32'h87654321, blank=00, exactly one frame_done pulse.
- Glitch: tube=FE seven=30 for 3 strobes, then seven=7E for 4 strobes -> digit0 commits 0; digit0 never equals 1.
- Invalid: tube=FB seven=01 held 4 strobes -> seg_err=1; nibble2 unchanged.
- Tube error: tube=FC held 4 strobes -> tube_err=1. tube=FF held 10 strobes -> no error, no commits.
- Stale (SEG_STALE_TIMEOUT_EN, TIMEOUT=20): commit digit3=A, then scan only digit0 for 25 strobes -> stale[3]=1, blank[3]=1; stale[0]=0.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Monitors a scanned seven-segment bus and rebuilds the 8-digit hex value being shown.
// Optional SEG_STALE_TIMEOUT_EN adds per-digit age counters and a `stale` output.
module seg_scan_decoder #(
  parameter int unsigned SAMPLE_DIV = 50,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned TIMEOUT    = 400
) (
  input  logic        clk1M,
  input  logic        rst,
  input  logic [6:0]  seven,
  input  logic [7:0]  tube,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic        frame_done,
  output logic        seg_err,
  output logic        tube_err
`ifdef SEG_STALE_TIMEOUT_EN
  ,
  output logic [7:0]  stale
`endif
);

  // Returns {valid, code} for a segment pattern.
  function automatic logic [4:0] glyph_lookup(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h7E:   r = 5'h10;
      7'h30:   r = 5'h11;
      7'h6D:   r = 5'h12;
      7'h79:   r = 5'h13;
      7'h33:   r = 5'h14;
      7'h5B:   r = 5'h15;
      7'h5F:   r = 5'h16;
      7'h70:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h7B:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h1F:   r = 5'h1B;
      7'h4E:   r = 5'h1C;
      7'h3D:   r = 5'h1D;
      7'h4F:   r = 5'h1E;
      7'h47:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [9:0]  div_q, div_d;
  logic [3:0]  stab_q, stab_d;
  logic [14:0] prev_q, prev_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  blank_q, blank_d;
  logic [7:0]  seen_q, seen_d;
  logic        frame_q, frame_d;
  logic        seg_err_q, seg_err_d;
  logic        tube_err_q, tube_err_d;

  logic        strobe;
  logic        same;
  logic [3:0]  cnt_next;
  logic        commit;
  logic        tube_onehot;
  logic [2:0]  idx;
  logic [4:0]  glyph;
  logic [7:0]  seen_acc;

  assign strobe      = (div_q == 10'(SAMPLE_DIV - 1));
  assign same        = ({tube, seven} == prev_q);
  assign cnt_next    = same ? ((stab_q == 4'd15) ? 4'd15 : stab_q + 4'd1) : 4'd1;
  // Saturated run at STABLE_CNT=15 must not re-commit on every strobe.
  assign commit      = strobe && (cnt_next == 4'(STABLE_CNT)) &&
                       !(same && (stab_q == 4'(STABLE_CNT)));
  assign tube_onehot = $onehot(~tube);
  assign glyph       = glyph_lookup(seven);

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!tube[i]) idx = 3'(i);
    end
  end

`ifdef SEG_STALE_TIMEOUT_EN
  logic [8:0] age_q [8];
  logic [8:0] age_d [8];
`endif

  always_comb begin
    div_d      = strobe ? 10'd0 : div_q + 10'd1;
    stab_d     = stab_q;
    prev_d     = prev_q;
    digits_d   = digits_q;
    blank_d    = blank_q;
    seg_err_d  = seg_err_q;
    tube_err_d = tube_err_q;
    // A full mask is cleared the cycle after it completes; same-cycle commits survive.
    seen_acc   = (seen_q == 8'hFF) ? 8'h00 : seen_q;

    if (strobe) begin
      stab_d = cnt_next;
      prev_d = {tube, seven};
    end

    if (commit && (tube != 8'hFF)) begin
      if (!tube_onehot) begin
        tube_err_d = 1'b1;
      end else begin
        seen_acc[idx] = 1'b1;
        if (seven == 7'd0) begin
          blank_d[idx] = 1'b1;
        end else if (glyph[4]) begin
          digits_d[idx*4 +: 4] = glyph[3:0];
          blank_d[idx]         = 1'b0;
        end else begin
          seg_err_d = 1'b1;
        end
      end
    end

`ifdef SEG_STALE_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      age_d[i] = age_q[i];
      if (strobe && (age_q[i] != 9'h1FF)) age_d[i] = age_q[i] + 9'd1;
      if (commit && tube_onehot && (idx == 3'(i))) age_d[i] = 9'd0;
      if (age_d[i] >= 9'(TIMEOUT)) blank_d[i] = 1'b1;
    end
`endif

    seen_d  = seen_acc;
    frame_d = (seen_acc == 8'hFF);
  end

  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      stab_q     <= '0;
      prev_q     <= '0;
      digits_q   <= '0;
      blank_q    <= 8'hFF;
      seen_q     <= '0;
      frame_q    <= 1'b0;
      seg_err_q  <= 1'b0;
      tube_err_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      stab_q     <= stab_d;
      prev_q     <= prev_d;
      digits_q   <= digits_d;
      blank_q    <= blank_d;
      seen_q     <= seen_d;
      frame_q    <= frame_d;
      seg_err_q  <= seg_err_d;
      tube_err_q <= tube_err_d;
    end
  end

`ifdef SEG_STALE_TIMEOUT_EN
  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) age_q[i] <= age_d[i];
    end
  end

  always_comb begin
    stale = 8'h00;
    for (int i = 0; i < 8; i++) stale[i] = (age_q[i] >= 9'(TIMEOUT));
  end
`endif

  assign digits     = digits_q;
  assign blank      = blank_q;
  assign frame_done = frame_q;
  assign seg_err    = seg_err_q;
  assign tube_err   = tube_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised bench for seg_scan_decoder against a hold-level reference model.
// Build with SEG_STALE_TIMEOUT_EN to also exercise the stale/age feature.
module tb_seg_scan_decoder;

  localparam int SD = 4;
  localparam int SC = 4;
  localparam int TO = 20;

  logic        clk1M = 1'b0;
  logic        rst   = 1'b1;
  logic [6:0]  seven = 7'd0;
  logic [7:0]  tube  = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic        frame_done, seg_err, tube_err;
`ifdef SEG_STALE_TIMEOUT_EN
  logic [7:0]  stale;
`endif

  seg_scan_decoder #(.SAMPLE_DIV(SD), .STABLE_CNT(SC), .TIMEOUT(TO)) dut (
    .clk1M      (clk1M),
    .rst        (rst),
    .seven      (seven),
    .tube       (tube),
    .digits     (digits),
    .blank      (blank),
    .frame_done (frame_done),
    .seg_err    (seg_err),
    .tube_err   (tube_err)
`ifdef SEG_STALE_TIMEOUT_EN
    ,
    .stale      (stale)
`endif
  );

  always #5 clk1M = ~clk1M;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model state, advanced once per hold.
  logic [31:0] m_digits;
  logic [7:0]  m_blank, m_seen;
  logic        m_seg_err, m_tube_err;
  logic [14:0] m_prev;
  int          m_run;
  int          m_frames = 0;
  int          m_age [8];
  int          frames_seen = 0;

  always @(negedge clk1M) if (frame_done === 1'b1) frames_seen++;

  task automatic model_reset();
    m_digits = '0; m_blank = 8'hFF; m_seen = '0; m_seg_err = 0; m_tube_err = 0;
    m_prev = '0; m_run = 0;
    for (int i = 0; i < 8; i++) m_age[i] = 0;
  endtask

  // Drive {t,s} for n strobes starting strobe-aligned, then update the model.
  task automatic hold(input logic [7:0] t, input logic [6:0] s, input int n);
    int rb, ci, k, code;
    logic [7:0] tn;
    tube = t; seven = s;
    repeat (n * SD) @(posedge clk1M);
    @(negedge clk1M);
    rb = ({t, s} == m_prev) ? m_run : 0;
    m_prev = {t, s};
    m_run = rb + n;
    ci = -1;
    k = SC - rb;
    tn = ~t;
    if (rb < SC && rb + n >= SC && t != 8'hFF) begin
      if ($countones(tn) != 1) begin
        m_tube_err = 1'b1;
      end else begin
        for (int i = 0; i < 8; i++) if (tn[i]) ci = i;
        code = -1;
        for (int g = 0; g < 16; g++) if (glyph_tab[g] == s) code = g;
        m_seen[ci] = 1'b1;
        if (s == 7'd0) m_blank[ci] = 1'b1;
        else if (code >= 0) begin
          m_digits[ci*4 +: 4] = 4'(code);
          m_blank[ci] = 1'b0;
        end else m_seg_err = 1'b1;
        if (m_seen == 8'hFF) begin
          m_frames++;
          m_seen = '0;
        end
      end
    end
`ifdef SEG_STALE_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      if (i == ci) m_age[i] = n - k;
      else m_age[i] = (m_age[i] + n > 511) ? 511 : m_age[i] + n;
      if (m_age[i] >= TO) m_blank[i] = 1'b1;
    end
`endif
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".digits"}, digits, m_digits);
    check_eq({tag, ".blank"}, 32'(blank), 32'(m_blank));
    check_eq({tag, ".seg_err"}, 32'(seg_err), 32'(m_seg_err));
    check_eq({tag, ".tube_err"}, 32'(tube_err), 32'(m_tube_err));
    check_eq({tag, ".frames"}, 32'(frames_seen), 32'(m_frames));
`ifdef SEG_STALE_TIMEOUT_EN
    begin
      logic [7:0] ms;
      for (int i = 0; i < 8; i++) ms[i] = (m_age[i] >= TO);
      check_eq({tag, ".stale"}, 32'(stale), 32'(ms));
    end
`endif
  endtask

  task automatic mid_reset(input string tag);
    @(negedge clk1M);
    #2 rst = 1'b1;
    #1;
    check_eq({tag, ".rst_digits"}, digits, 32'h0);
    check_eq({tag, ".rst_blank"}, 32'(blank), 32'hFF);
    check_eq({tag, ".rst_frame"}, 32'(frame_done), 32'h0);
    check_eq({tag, ".rst_errs"}, 32'({seg_err, tube_err}), 32'h0);
    model_reset();
    @(negedge clk1M);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] t;
    logic [6:0] s;
    int r;
    model_reset();
    repeat (3) @(negedge clk1M);
    check_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) hold(~(8'h01 << i), glyph_tab[i + 1], 5);
    check_all("frame");
    check_eq("frame.value", digits, 32'h87654321);
    check_eq("frame.pulses", 32'(frames_seen), 32'd1);

    hold(8'hFE, 7'h30, 3);
    hold(8'hFE, 7'h7E, 4);
    check_all("glitch");
    check_eq("glitch.digit0", 32'(digits[3:0]), 32'h0);

    hold(8'hFB, 7'h01, 4);
    check_all("invalid");
    check_eq("invalid.nibble2", 32'(digits[11:8]), 32'h3);

    hold(8'hFC, 7'h30, 4);
    hold(8'hFF, 7'h00, 10);
    check_all("tube_err");

`ifdef SEG_STALE_TIMEOUT_EN
    hold(8'hF7, 7'h77, 5);
    for (int j = 0; j < 5; j++) hold(8'hFE, (j % 2 == 0) ? 7'h7E : 7'h30, 5);
    check_all("stale");
    check_eq("stale.bit3", 32'({stale[3], blank[3]}), 32'h3);
    check_eq("stale.bit0", 32'(stale[0]), 32'h0);
`endif

    mid_reset("mid");
    check_all("after_reset");

    for (int h = 0; h < 160; h++) begin
      r = $urandom_range(0, 9);
      if (r == 0) t = 8'hFF;
      else if (r == 1) t = 8'($urandom);
      else t = ~(8'h01 << $urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r < 7) s = glyph_tab[$urandom_range(0, 15)];
      else if (r == 7) s = 7'd0;
      else s = 7'($urandom);
      hold(t, s, $urandom_range(1, 6));
      check_all("rand");
      if (h == 80) mid_reset("rand_mid");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
